// File: rtl/flappy_pkg.sv
// flappy_pkg: shared phase encoding and default timing constants for the flappy-bird core
package flappy_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DYING     = 3'd4,
    ST_OVER      = 3'd5
  } state_e;
  localparam int SCORE_W             = 16;
  localparam int TICK_DIV_DEF        = 10_000_000;
  localparam int COUNTDOWN_TICKS_DEF = 30;
  localparam int DYING_TICKS_DEF     = 20;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running divider emitting a registered one-cycle pulse at each wrap
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_raw
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_d, cnt_q;
  logic tick_d, tick_q;
  logic wrap;
  assign wrap = cnt_q == W'(DIV - 1);
  // clear restarts the period so the first pulse lands a full period later
  always_comb begin
    cnt_d  = clr || wrap ? '0 : cnt_q + 1'b1;
    tick_d = !clr && wrap;
  end
  // divider state, asynchronously reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick_raw = tick_q;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round phase FSM, physics tick gating, core reset and session high score
module game_sequencer #(
  parameter int TICK_DIV        = flappy_pkg::TICK_DIV_DEF,
  parameter int COUNTDOWN_TICKS = flappy_pkg::COUNTDOWN_TICKS_DEF,
  parameter int DYING_TICKS     = flappy_pkg::DYING_TICKS_DEF,
  parameter int SCORE_W         = flappy_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               fail,
  input  logic [SCORE_W-1:0] score,
  output logic               tick,
  output logic               core_rst,
  output logic [2:0]         state,
  output logic [1:0]         countdown,
  output logic               mode_lat,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record
);
  import flappy_pkg::*;
  localparam int CD_W = $clog2(COUNTDOWN_TICKS + 1);
  localparam int DY_W = $clog2(DYING_TICKS + 1);
  state_e state_d, state_q;
  logic [CD_W-1:0] cd_d, cd_q;
  logic [DY_W-1:0] dy_d, dy_q;
  logic [SCORE_W-1:0] high_score_d, high_score_q;
  logic mode_lat_d, mode_lat_q, new_record_d, new_record_q;
  logic start_q, start_rise, tick_raw, clr;
  assign start_rise = start & ~start_q;
  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick_raw (tick_raw)
  );
  // phase transitions; clr realigns the divider on every countdown entry
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    dy_d         = dy_q;
    mode_lat_d   = mode_lat_q;
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    clr          = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: if (start_rise) begin
        state_d      = ST_COUNTDOWN;
        cd_d         = CD_W'(COUNTDOWN_TICKS - 1);
        mode_lat_d   = mode;
        new_record_d = 1'b0;
        clr          = 1'b1;
      end
      ST_COUNTDOWN: if (tick_raw) begin
        if (cd_q == '0) state_d = ST_PLAY;
        else cd_d = cd_q - 1'b1;
      end
      ST_PLAY: if (fail) begin
        state_d = ST_DYING;
        dy_d    = DY_W'(DYING_TICKS - 1);
      end else if (start_rise) state_d = ST_PAUSE;
      ST_PAUSE: if (start_rise) state_d = ST_PLAY;
      ST_DYING: if (tick_raw) begin
        if (dy_q == '0) begin
          state_d = ST_OVER;
          if (score > high_score_q) begin
            high_score_d = score;
            new_record_d = 1'b1;
          end
        end else dy_d = dy_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // sequencer registers, all cleared by the board reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cd_q         <= '0;
      dy_q         <= '0;
      mode_lat_q   <= 1'b0;
      high_score_q <= '0;
      new_record_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      dy_q         <= dy_d;
      mode_lat_q   <= mode_lat_d;
      high_score_q <= high_score_d;
      new_record_q <= new_record_d;
      start_q      <= start;
    end
  end
  assign tick       = tick_raw & (state_q == ST_PLAY || state_q == ST_DYING);
  assign core_rst   = !(state_q == ST_IDLE || state_q == ST_COUNTDOWN);
  assign state      = state_q;
  assign countdown  = state_q != ST_COUNTDOWN ? 2'd0 :
                      cd_q >= CD_W'(2 * COUNTDOWN_TICKS / 3) ? 2'd3 :
                      cd_q >= CD_W'(COUNTDOWN_TICKS / 3) ? 2'd2 : 2'd1;
  assign mode_lat   = mode_lat_q;
  assign high_score = high_score_q;
  assign new_record = new_record_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized rounds against a timing model, with a decoupled scoreboard monitor
module tb_game_sequencer;
  localparam int DIV = 4, CT = 6, DT = 2, SW = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_PAUSE = 3'd3, S_DYING = 3'd4, S_OVER = 3'd5;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, fail = 1'b0;
  logic [SW-1:0] score = '0;
  logic tick, core_rst, mode_lat, new_record;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [SW-1:0] high_score;

  game_sequencer #(.TICK_DIV(DIV), .COUNTDOWN_TICKS(CT), .DYING_TICKS(DT), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fail(fail), .score(score),
    .tick(tick), .core_rst(core_rst), .state(state), .countdown(countdown),
    .mode_lat(mode_lat), .high_score(high_score), .new_record(new_record)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [2:0]    st;
    logic          ml;
    logic [SW-1:0] hs;
    logic          nr;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  bit mon_en = 1'b0;
  logic [2:0] prev = S_IDLE, phase = S_IDLE;
  int c0 = -1000;
  logic [SW-1:0] hs_m = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  task automatic push(input int c, input logic [2:0] s, input logic ml, input logic [SW-1:0] h, input logic nr);
    exp_t e;
    e.cyc = c; e.st = s; e.ml = ml; e.hs = h; e.nr = nr;
    q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_state", state, S_IDLE);
    chk("rst_tick", tick, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_countdown", countdown, 0);
    chk("rst_mode_lat", mode_lat, 0);
    chk("rst_high_score", high_score, 0);
    chk("rst_new_record", new_record, 0);
  endtask

  // monitor: pops expected phase changes, and checks per-cycle outputs against the model phase
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      int j, k;
      if (state != prev) begin
        if (q.size() == 0) chk("unexpected_state_change", state, prev);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("state", state, e.st);
          chk("change_cycle", cyc, e.cyc);
          chk("mode_lat", mode_lat, e.ml);
          chk("high_score", high_score, e.hs);
          chk("new_record", new_record, e.nr);
          phase = e.st;
          if (e.st == S_CD) c0 = e.cyc;
        end
        prev = state;
      end
      if (q.size() != 0 && q[0].cyc < cyc) begin
        chk("missed_change", cyc, q[0].cyc);
        phase = q[0].st;
        if (q[0].st == S_CD) c0 = q[0].cyc;
        void'(q.pop_front());
      end
      chk("tick", tick, (phase == S_PLAY || phase == S_DYING) && cyc > c0 && (cyc - c0) % DIV == 0);
      chk("core_rst", core_rst, !(phase == S_IDLE || phase == S_CD));
      j = cyc - c0;
      k = j <= 0 ? 0 : (j - 1) / DIV;
      chk("countdown", countdown, phase == S_CD ? 3 - (k * 3) / CT : 0);
    end
  end

  task automatic run_round(input logic m, input logic [SW-1:0] sc, input bit pz, input bit rc, input bit noise, input bit abort);
    int cs, pl, d, t, ov;
    logic nr;
    mode = m; start = 1'b1; cs = cyc + 1;
    push(cs, S_CD, m, hs_m, 1'b0);
    pl = cs + CT * DIV + 1;
    push(pl, S_PLAY, m, hs_m, 1'b0);
    @(negedge clk); start = 1'b0; mode = 1'($urandom_range(0, 1));
    if (noise) begin
      wait_until(cyc + $urandom_range(2, 10));
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    wait_until(pl + $urandom_range(1, 6));
    if (pz) begin
      start = 1'b1; push(cyc + 1, S_PAUSE, m, hs_m, 1'b0); @(negedge clk); start = 1'b0;
      fail = 1'b1; @(negedge clk); fail = 1'b0;
      wait_until(cyc + $urandom_range(3, 9));
      start = 1'b1; push(cyc + 1, S_PLAY, m, hs_m, 1'b0); @(negedge clk); start = 1'b0;
      wait_until(cyc + $urandom_range(1, 5));
    end
    score = sc; fail = 1'b1; start = rc; d = cyc + 1;
    push(d, S_DYING, m, hs_m, 1'b0);
    @(negedge clk); fail = 1'b0; start = 1'b0;
    if (!abort) begin
      t = d;
      while (!(t > cs && (t - cs) % DIV == 0)) t++;
      ov = t + DIV * (DT - 1) + 1;
      nr = sc > hs_m;
      if (nr) hs_m = sc;
      push(ov, S_OVER, m, hs_m, nr);
      wait_until(ov + $urandom_range(1, 4));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values();
    rst = 1'b1; prev = S_IDLE; phase = S_IDLE; mon_en = 1'b1;
    repeat (100) @(negedge clk);
    run_round(1'b1, 16'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    run_round(1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    run_round(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      run_round(1'($urandom_range(0, 1)), 16'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    run_round(1'b1, 16'd40, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("queue_drained", q.size(), 0);
    chk("pre_reset_high_score", high_score, hs_m);
    chk("pre_reset_state", state, S_DYING);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_values();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
